data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port arbiter placed in front of the single-port data memory (16-bit byte address, 8-bit data, synchronous read) so the CPU and a second bus master (loader/DMA/peripheral) share it. It grants one access per cycle with a round-robin policy and a bounded burst, drives the memory's address, write-data and write-enable, and returns read data to the correct requester with a tagged valid pulse after the fixed memory read latency.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, cycles from a read grant to memory data valid (≥1)
- MAX_BURST, 4, max consecutive grants to one owner while the other requests (≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held with its command until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access accepted this cycle
- rvalid0 / rvalid1  out  1  rdata belongs to this requester this cycle
- rdata  out  DATA_W  read data, shared by both requesters (= mem_rdata)
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory

## Operation
- FSM states IDLE, OWN0, OWN1; reset → IDLE, rr pointer → 0, burst_cnt → 0, read pipeline cleared.
- gntX = (state == OWNX) & reqX, combinational; at most one grant per cycle.
- During a grant: mem_addr/mem_wdata = owner's addr/wdata, mem_we = owner's we. No grant: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- IDLE: both req → OWN of rr pointer; one req → that OWN; none → stay.
- OWNX, reqX low: other requesting → OWN other; else → IDLE. burst_cnt → 0.
- OWNX, reqX high (grant): other requesting and burst_cnt == MAX_BURST-1 → OWN other, burst_cnt → 0, pointer → other; otherwise stay, burst_cnt += 1 (saturating at MAX_BURST-1 if other idle).
- Read tag pipeline: RD_LAT-deep shift register of {valid, id}; entered on each read grant (we = 0); writes produce no rvalid.
- rvalidX = pipeline output valid & id == X; rdata = mem_rdata unconditionally.

## Timing
- Reset values: gnt0/1 = 0, rvalid0/1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Idle-to-grant latency: 1 cycle (req sampled in IDLE, grant next cycle).
- Ownership handover OWN0→OWN1: zero bubble on burst expiry; one bubble cycle when owner drops req while the other waits.
- Read data: rvalid pulse exactly RD_LAT cycles after the grant cycle; back-to-back read grants yield back-to-back rvalid pulses in grant order.
- Requester must keep req/we/addr/wdata stable until the gnt cycle; may change them the cycle after gnt.
- rst asserted mid-operation: outputs to reset values immediately; in-flight reads discarded (no rvalid).
- Starvation bound: a waiting requester is granted within MAX_BURST+1 cycles.

## Structure
- Shared package: state enum (IDLE, OWN0, OWN1), requester id type (1 bit), default ADDR_W/DATA_W constants.
- One sub-module natural: read_tag_pipe (RD_LAT-deep {valid, id} shift register with async active-low clear).

## Test plan
- Reset: rst = 0 with req0 = req1 = 1 → gnt0 = gnt1 = 0, mem_we = 0, rvalid0/1 = 0; release → first grant goes to requester 0.
- Single read: req0, addr0 = 0x0010, memory holds 0x5A there → gnt0 one cycle later with mem_addr = 0x0010, rvalid0 = 1 and rdata = 0x5A RD_LAT cycles after gnt.
- Write: req1, we1 = 1, addr1 = 0x0200, wdata1 = 0xAB → one cycle mem_we = 1, mem_addr = 0x0200, mem_wdata = 0xAB; no rvalid; readback via port 0 returns 0xAB.
- Contention, MAX_BURST = 4, both req held high → grant sequence 0,0,0,0,1,1,1,1,0,… with no idle cycles between bursts.
- Pipelined reads: requester 0 reads 0x0001, 0x0002, 0x0003 on consecutive grants → three consecutive rvalid0 pulses with matching data in order.
- Reset during in-flight read: rst low in the cycle after gnt0 for a read → no rvalid0 ever produced, state IDLE after release.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter_pkg : shared types and defaults for the data memory arbiter
// Rev 1.0
// ============================================================================
package data_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t ID0 = 1'b0;
  localparam req_id_t ID1 = 1'b1;

  function automatic arb_state_t own_state(input req_id_t id);
    return (id == ID1) ? OWN1 : OWN0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter_if : requester and data-memory signals of the arbiter
// Rev 1.0
// ============================================================================
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // master: requesters plus the memory itself; slave: the arbiter
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_read_tag_pipe.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter_read_tag_pipe : RD_LAT-deep {valid, id} tag shift register
// Rev 1.0
// ============================================================================
module data_mem_arbiter_read_tag_pipe
  import data_mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    in_valid,
  input  wire req_id_t in_id,
  output logic         out_valid,
  output req_id_t      out_id
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] id_q;

  if (RD_LAT == 1) begin : g_single
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= '0;
        id_q    <= '0;
      end else begin
        valid_q <= in_valid;
        id_q    <= in_id;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= '0;
        id_q    <= '0;
      end else begin
        valid_q <= {valid_q[RD_LAT-2:0], in_valid};
        id_q    <= {id_q[RD_LAT-2:0], in_id};
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_id    = id_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter : round-robin, burst-bounded two-master data memory arbiter
// Rev 1.0
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  data_mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  arb_state_t       state, state_nxt;
  req_id_t          rr_ptr, ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;

  logic    gnt0, gnt1;
  logic    own_req, oth_req;
  req_id_t own_id;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  logic    rd_issue;
  req_id_t rd_id;
  logic    tag_valid;
  req_id_t tag_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= ID0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= ptr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  assign gnt0 = (state == OWN0) && bus.req0;
  assign gnt1 = (state == OWN1) && bus.req1;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    ptr_nxt   = rr_ptr;
    own_id    = (state == OWN1) ? ID1 : ID0;
    own_req   = (own_id == ID1) ? bus.req1 : bus.req0;
    oth_req   = (own_id == ID1) ? bus.req0 : bus.req1;

    case (state)
      IDLE: begin
        burst_nxt = '0;
        if (bus.req0 && bus.req1) begin
          state_nxt = own_state(rr_ptr);
        end else if (bus.req0) begin
          state_nxt = OWN0;
        end else if (bus.req1) begin
          state_nxt = OWN1;
        end
      end

      OWN0, OWN1: begin
        if (!own_req) begin
          burst_nxt = '0;
          state_nxt = oth_req ? own_state(~own_id) : IDLE;
        end else if (oth_req && (burst_cnt == BURST_LAST)) begin
          // burst expired with the other side waiting: hand over without a bubble
          state_nxt = own_state(~own_id);
          burst_nxt = '0;
          ptr_nxt   = ~own_id;
        end else if (burst_cnt != BURST_LAST) begin
          burst_nxt = burst_cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (gnt0) begin
      addr_mux  = bus.addr0;
      wdata_mux = bus.wdata0;
      we_mux    = bus.we0;
    end else if (gnt1) begin
      addr_mux  = bus.addr1;
      wdata_mux = bus.wdata1;
      we_mux    = bus.we1;
    end
  end

  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = we_mux;
  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;

  assign rd_issue = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
  assign rd_id    = gnt1 ? ID1 : ID0;

  data_mem_arbiter_read_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_issue),
    .in_id     (rd_id),
    .out_valid (tag_valid),
    .out_id    (tag_id)
  );

  assign bus.rvalid0 = tag_valid && (tag_id == ID0);
  assign bus.rvalid1 = tag_valid && (tag_id == ID1);
  assign bus.rdata   = bus.mem_rdata;

  a_one_grant : assert property (@(posedge clk) disable iff (!rst) !(gnt0 && gnt1));

endmodule
`default_nettype wire
